// File: rtl/synapse_row_mc.sv
// synapse_row_mc -- one row of a neuromorphic synapse array.
// Each synapse holds a serially loaded {addr, weight} config word. Spikes whose
// address matches a synapse add its weight to that synapse's saturating current.
// Currents decay periodically, and each column's currents are summed into a
// registered dendrite current.
// Optional feature: define SYNAPSE_ROW_MC_SPIKE_CNT_EN to enable the 16-bit
// accepted-spike counter; otherwise spike_count is tied to zero.
module synapse_row_mc #(
    parameter int NUM_COLS     = 2,
    parameter int SYN_PER_COL  = 2,
    parameter int ADDR_W       = 4,
    parameter int WEIGHT_W     = 5,
    parameter int CUR_W        = 8,
    parameter int DECAY_SHIFT  = 2,
    parameter int DECAY_PERIOD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_en,
    input  logic                      cfg_data_in,
    output logic                      cfg_data_out,
    input  logic                      spike_valid,
    input  logic [ADDR_W-1:0]         spike_addr,
    output logic                      spike_ready,
    output logic [NUM_COLS*CUR_W-1:0] dendrite_current,
    output logic [15:0]               spike_count
);

    localparam int NUM_SYN = NUM_COLS * SYN_PER_COL;
    localparam int CFG_W   = ADDR_W + WEIGHT_W;
    localparam int CHAIN_W = NUM_SYN * CFG_W;
    // Headroom for decay/add of one current and for summing a whole column.
    localparam int MATH_W  = CUR_W + $clog2(SYN_PER_COL) + 2;
    localparam int DCNT_W  = (DECAY_PERIOD > 32'sd1) ? $clog2(DECAY_PERIOD) : 1;
    localparam bit DECAY_ON = (DECAY_PERIOD != 32'sd0);
    localparam logic signed [MATH_W-1:0] CUR_MAX_M = MATH_W'((64'sd1 <<< (CUR_W - 1)) - 64'sd1);
    localparam logic signed [MATH_W-1:0] CUR_MIN_M = ~CUR_MAX_M;

    logic [CHAIN_W-1:0]        chain_r;
    logic                      s1_valid_r;
    logic [ADDR_W-1:0]         s1_addr_r;
    logic [DCNT_W-1:0]         dcnt_r;
    logic                      tick_s;
    logic                      accept_s;
    logic [CUR_W-1:0]          cur_r     [NUM_SYN];
    logic [CUR_W-1:0]          cur_nxt_s [NUM_SYN];
    logic [NUM_COLS*CUR_W-1:0] dend_r;
    logic [NUM_COLS*CUR_W-1:0] dend_nxt_s;

    function automatic logic signed [MATH_W-1:0] sext_cur(input logic [CUR_W-1:0] v);
        return {{(MATH_W - CUR_W){v[CUR_W-1]}}, v};
    endfunction

    function automatic logic signed [MATH_W-1:0] sext_wt(input logic [WEIGHT_W-1:0] v);
        return {{(MATH_W - WEIGHT_W){v[WEIGHT_W-1]}}, v};
    endfunction

    // Clamp a wide signed value into the CUR_W two's-complement range.
    function automatic logic [CUR_W-1:0] sat_cur(input logic signed [MATH_W-1:0] v);
        logic [CUR_W-1:0] r;
        if (v > CUR_MAX_M) begin
            r = CUR_MAX_M[CUR_W-1:0];
        end else if (v < CUR_MIN_M) begin
            r = CUR_MIN_M[CUR_W-1:0];
        end else begin
            r = v[CUR_W-1:0];
        end
        return r;
    endfunction

    // Move toward zero by max(|v| >> DECAY_SHIFT, 1); the step never exceeds |v|.
    function automatic logic signed [MATH_W-1:0] decay_step(input logic signed [MATH_W-1:0] v);
        logic signed [MATH_W-1:0] mag_v;
        logic signed [MATH_W-1:0] amt_v;
        mag_v = v[MATH_W-1] ? -v : v;
        amt_v = mag_v >>> DECAY_SHIFT;
        amt_v = (amt_v == {MATH_W{1'b0}}) ? MATH_W'(1) : amt_v;
        return v[MATH_W-1] ? (v + amt_v) : ((v == {MATH_W{1'b0}}) ? v : (v - amt_v));
    endfunction

    assign spike_ready      = ~cfg_en;
    assign accept_s         = spike_valid & ~cfg_en;
    assign cfg_data_out     = chain_r[CHAIN_W-1];
    assign dendrite_current = dend_r;
    assign tick_s           = DECAY_ON && (dcnt_r == DCNT_W'(DECAY_PERIOD - 1));

    // Free-running decay counter; wraps when the tick fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dcnt_r <= {DCNT_W{1'b0}};
        end else if (!DECAY_ON || tick_s) begin
            dcnt_r <= {DCNT_W{1'b0}};
        end else begin
            dcnt_r <= dcnt_r + DCNT_W'(1);
        end
    end

    // Serial configuration chain: synapse 0 at the LSB end, output from the top bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_r <= {CHAIN_W{1'b0}};
        end else if (cfg_en) begin
            chain_r <= {chain_r[CHAIN_W-2:0], cfg_data_in};
        end else begin
            chain_r <= chain_r;
        end
    end

    // Stage 1: capture the accepted spike for matching on the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            s1_addr_r  <= accept_s ? spike_addr : s1_addr_r;
        end
    end

    // Next synapse currents: decay first, then add matching weight, then saturate.
    always_comb begin : next_cur_p
        logic [WEIGHT_W-1:0]      wt_v;
        logic [ADDR_W-1:0]        ad_v;
        logic signed [MATH_W-1:0] acc_v;
        logic                     hit_v;
        wt_v  = {WEIGHT_W{1'b0}};
        ad_v  = {ADDR_W{1'b0}};
        acc_v = {MATH_W{1'b0}};
        hit_v = 1'b0;
        for (int k = 0; k < NUM_SYN; k++) begin
            wt_v  = chain_r[k*CFG_W +: WEIGHT_W];
            ad_v  = chain_r[k*CFG_W + WEIGHT_W +: ADDR_W];
            acc_v = sext_cur(cur_r[k]);
            acc_v = tick_s ? decay_step(acc_v) : acc_v;
            hit_v = s1_valid_r && (ad_v == s1_addr_r) && (wt_v != {WEIGHT_W{1'b0}});
            acc_v = acc_v + (hit_v ? sext_wt(wt_v) : {MATH_W{1'b0}});
            cur_nxt_s[k] = sat_cur(acc_v);
        end
    end

    // Synapse current registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SYN; k++) begin
                cur_r[k] <= {CUR_W{1'b0}};
            end
        end else begin
            cur_r <= cur_nxt_s;
        end
    end

    // Saturated per-column sum of the synapse currents.
    always_comb begin : col_sum_p
        logic signed [MATH_W-1:0] sum_v;
        sum_v      = {MATH_W{1'b0}};
        dend_nxt_s = {(NUM_COLS*CUR_W){1'b0}};
        for (int j = 0; j < NUM_COLS; j++) begin
            sum_v = {MATH_W{1'b0}};
            for (int s = 0; s < SYN_PER_COL; s++) begin
                sum_v = sum_v + sext_cur(cur_r[j*SYN_PER_COL + s]);
            end
            dend_nxt_s[j*CUR_W +: CUR_W] = sat_cur(sum_v);
        end
    end

    // Registered dendrite current output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dend_r <= {(NUM_COLS*CUR_W){1'b0}};
        end else begin
            dend_r <= dend_nxt_s;
        end
    end

`ifdef SYNAPSE_ROW_MC_SPIKE_CNT_EN
    logic [15:0] spike_count_r;

    // Accepted-spike counter, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spike_count_r <= 16'd0;
        end else if (accept_s) begin
            spike_count_r <= spike_count_r + 16'd1;
        end else begin
            spike_count_r <= spike_count_r;
        end
    end

    assign spike_count = spike_count_r;
`else
    assign spike_count = 16'd0;
`endif

endmodule

// File: tb/tb_synapse_row_mc.sv
// Self-checking bench for synapse_row_mc: two instances (decay period 4 and
// decay disabled) share all inputs and are compared every cycle against an
// integer reference model, plus directed checks of the key scenarios.
module tb_synapse_row_mc;

    localparam int NC  = 2;
    localparam int SPC = 2;
    localparam int NS  = NC * SPC;
    localparam int AW  = 4;
    localparam int WW  = 5;
    localparam int CW  = 8;
    localparam int DS  = 2;
    localparam int CFW = AW + WW;
    localparam int CHW = NS * CFW;
    localparam int PER = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_en;
    logic          cfg_data_in;
    logic          spike_valid;
    logic [AW-1:0] spike_addr;
    logic          cdo0, cdo1, rdy0, rdy1;
    logic [NC*CW-1:0] dc0, dc1;
    logic [15:0]   cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int           m_cur  [2][NS];
    int           m_dend [2][NC];
    bit [CHW-1:0] m_chain;
    bit           m_s1_v;
    int           m_s1_a;
    int           m_cnt;
    int           m_edge;

    always #5 clk = ~clk;

    synapse_row_mc #(.NUM_COLS(NC), .SYN_PER_COL(SPC), .ADDR_W(AW), .WEIGHT_W(WW),
                     .CUR_W(CW), .DECAY_SHIFT(DS), .DECAY_PERIOD(PER)) u_dut (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_data_in(cfg_data_in),
        .cfg_data_out(cdo0), .spike_valid(spike_valid), .spike_addr(spike_addr),
        .spike_ready(rdy0), .dendrite_current(dc0), .spike_count(cnt0));

    synapse_row_mc #(.NUM_COLS(NC), .SYN_PER_COL(SPC), .ADDR_W(AW), .WEIGHT_W(WW),
                     .CUR_W(CW), .DECAY_SHIFT(DS), .DECAY_PERIOD(0)) u_nd (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_data_in(cfg_data_in),
        .cfg_data_out(cdo1), .spike_valid(spike_valid), .spike_addr(spike_addr),
        .spike_ready(rdy1), .dendrite_current(dc1), .spike_count(cnt1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic int m_sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int m_decay(input int c);
        int d;
        d = ((c < 0) ? -c : c) >> DS;
        if (d < 1) d = 1;
        if (c > 0) return (c - d < 0) ? 0 : c - d;
        if (c < 0) return (c + d > 0) ? 0 : c + d;
        return 0;
    endfunction

    function automatic int m_weight(input int k);
        bit [WW-1:0] b;
        b = m_chain[k*CFW +: WW];
        return b[WW-1] ? int'(b) - 32 : int'(b);
    endfunction

    function automatic int m_addr(input int k);
        bit [AW-1:0] b;
        b = m_chain[k*CFW + WW +: AW];
        return int'(b);
    endfunction

    function automatic bit [CHW-1:0] cfg4(input int a0, input int w0, input int a1, input int w1,
                                          input int a2, input int w2, input int a3, input int w3);
        int a [NS];
        int w [NS];
        bit [CHW-1:0] v;
        a = '{a0, a1, a2, a3};
        w = '{w0, w1, w2, w3};
        v = '0;
        for (int k = 0; k < NS; k++) v[k*CFW +: CFW] = {a[k][AW-1:0], w[k][WW-1:0]};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NS; k++) m_cur[i][k] = 0;
            for (int j = 0; j < NC; j++) m_dend[i][j] = 0;
        end
        m_chain = '0;
        m_s1_v  = 1'b0;
        m_s1_a  = 0;
        m_cnt   = 0;
        m_edge  = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit acc;
        bit tick;
        int s;
        int c;
        acc = spike_valid && !cfg_en;
        for (int i = 0; i < 2; i++) begin
            tick = (i == 0) && ((m_edge % PER) == PER - 1);
            for (int j = 0; j < NC; j++) begin
                s = 0;
                for (int t = 0; t < SPC; t++) s += m_cur[i][j*SPC + t];
                m_dend[i][j] = m_sat(s);
            end
            for (int k = 0; k < NS; k++) begin
                c = m_cur[i][k];
                if (tick) c = m_decay(c);
                if (m_s1_v && m_addr(k) == m_s1_a && m_weight(k) != 0) c += m_weight(k);
                m_cur[i][k] = m_sat(c);
            end
        end
        m_s1_v = acc;
        m_s1_a = int'(spike_addr);
        if (cfg_en) m_chain = {m_chain[CHW-2:0], cfg_data_in};
        if (acc) m_cnt = (m_cnt + 1) % 65536;
        m_edge++;
    endtask

    task automatic check_all();
        logic [7:0] o8;
        logic [7:0] e8;
        int ec;
        for (int j = 0; j < NC; j++) begin
            o8 = dc0[j*CW +: CW];
            e8 = 8'(m_dend[0][j]);
            chk("dend_decay", {24'd0, o8}, {24'd0, e8});
            o8 = dc1[j*CW +: CW];
            e8 = 8'(m_dend[1][j]);
            chk("dend_nodecay", {24'd0, o8}, {24'd0, e8});
        end
        chk("cfg_out_decay", {31'd0, cdo0}, {31'd0, m_chain[CHW-1]});
        chk("cfg_out_nodecay", {31'd0, cdo1}, {31'd0, m_chain[CHW-1]});
        chk("ready_decay", {31'd0, rdy0}, {31'd0, ~cfg_en});
        chk("ready_nodecay", {31'd0, rdy1}, {31'd0, ~cfg_en});
`ifdef SYNAPSE_ROW_MC_SPIKE_CNT_EN
        ec = m_cnt;
`else
        ec = 0;
`endif
        chk("count_decay", {16'd0, cnt0}, ec);
        chk("count_nodecay", {16'd0, cnt1}, ec);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic spike(input int a);
        spike_valid = 1'b1;
        spike_addr  = AW'(a);
        step();
        spike_valid = 1'b0;
    endtask

    // Shift a full chain image in, first bit sent = v[CHW-1]; spikes offered meanwhile must be refused.
    task automatic shift_vec(input bit [CHW-1:0] v);
        for (int i = CHW - 1; i >= 0; i--) begin
            cfg_en      = 1'b1;
            cfg_data_in = v[i];
            spike_valid = 1'($urandom_range(0, 1));
            spike_addr  = AW'($urandom_range(0, 15));
            step();
        end
        cfg_en      = 1'b0;
        cfg_data_in = 1'b0;
        spike_valid = 1'b0;
    endtask

    task automatic do_reset();
        cfg_en      = 1'b0;
        spike_valid = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic align_tick();
        while ((m_edge % PER) != 0) step();
    endtask

    // Record distinct successive values of the decaying column 0 and compare to a table.
    task automatic decay_run(input int sgn);
        int q[$];
        int v;
        int exp_seq [13];
        exp_seq = '{10, 20, 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
        align_tick();
        spike_valid = 1'b1;
        spike_addr  = AW'(2);
        step();
        step();
        spike_valid = 1'b0;
        for (int n = 0; n < 60; n++) begin
            v = int'($signed(dc0[CW-1:0]));
            if (q.size() == 0 ? (v != 0) : (v != q[$])) q.push_back(v);
            step();
        end
        chk("decay_len", q.size(), 13);
        for (int i = 0; i < 13 && i < q.size(); i++) chk("decay_seq", q[i], sgn * exp_seq[i]);
        chk("decay_final", {24'd0, dc0[CW-1:0]}, 32'd0);
    endtask

    initial begin
        bit [CHW-1:0] pat;
        reset       = 1'b0;
        cfg_en      = 1'b0;
        cfg_data_in = 1'b0;
        spike_valid = 1'b0;
        spike_addr  = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // matched spike on the no-decay instance
        shift_vec(cfg4(3, 5, 3, 7, 9, 2, 10, -3));
        step();
        spike(3);
        step();
        chk("match_t1_col0", {24'd0, dc1[7:0]}, 32'd0);
        step();
        chk("match_col0", {24'd0, dc1[7:0]}, 32'd12);
        chk("match_col1", {24'd0, dc1[15:8]}, 32'd0);
        spike(4);
        step();
        step();
        chk("nomatch_col0", {24'd0, dc1[7:0]}, 32'd12);

        // handshake: cfg_en blocks acceptance
        cfg_en      = 1'b1;
        spike_valid = 1'b1;
        spike_addr  = AW'(3);
        #1;
        chk("ready_low", {31'd0, rdy1}, 32'd0);
        repeat (3) step();
        cfg_en      = 1'b0;
        spike_valid = 1'b0;
        step();
        step();
        chk("blocked_col0", {24'd0, dc1[7:0]}, 32'd12);

        // bring column 0 to 40, then reset mid-operation
        shift_vec(cfg4(2, 14, 2, 14, 9, 2, 10, -3));
        spike(2);
        step();
        step();
        chk("pre_reset_col0", {24'd0, dc1[7:0]}, 32'd40);
        do_reset();

        // saturation on the no-decay instance
        shift_vec(cfg4(1, 15, 1, 15, 9, 2, 10, -3));
        spike_valid = 1'b1;
        spike_addr  = AW'(1);
        for (int n = 0; n < 10; n++) begin
            step();
            chk("sat_nonneg", {31'd0, dc1[7]}, 32'd0);
        end
        spike_valid = 1'b0;
        repeat (2) step();
        chk("sat_col0", {24'd0, dc1[7:0]}, 32'd127);
        spike(1);
        step();
        step();
        chk("sat_hold_col0", {24'd0, dc1[7:0]}, 32'd127);

        // chain readback: fixed pattern then a random one
        for (int p = 0; p < 2; p++) begin
            pat = (p == 0) ? 36'h0A5C396E1 : CHW'({$urandom, $urandom});
            shift_vec(pat);
            for (int i = CHW - 1; i >= 0; i--) begin
                chk("readback", {31'd0, cdo0}, {31'd0, pat[i]});
                cfg_en      = 1'b1;
                cfg_data_in = 1'b0;
                step();
            end
            cfg_en = 1'b0;
        end

        // decay from +20 and from -20
        do_reset();
        shift_vec(cfg4(2, 10, 0, 0, 0, 0, 0, 0));
        decay_run(1);
        shift_vec(cfg4(2, -10, 0, 0, 0, 0, 0, 0));
        decay_run(-1);

        // randomized traffic against the model, with one reset in the middle
        for (int r = 0; r < 2; r++) begin
            do_reset();
            spike_valid = 1'b1;
            spike_addr  = AW'($urandom_range(0, 3));
            step();
            shift_vec(cfg4($urandom_range(0, 3), int'($urandom_range(0, 31)) - 16,
                           $urandom_range(0, 3), int'($urandom_range(0, 31)) - 16,
                           $urandom_range(0, 3), int'($urandom_range(0, 31)) - 16,
                           $urandom_range(0, 3), int'($urandom_range(0, 31)) - 16));
            for (int n = 0; n < 300; n++) begin
                cfg_en      = ($urandom_range(0, 9) == 0);
                cfg_data_in = 1'($urandom_range(0, 1));
                spike_valid = ($urandom_range(0, 3) != 0);
                spike_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15))
                                                         : AW'($urandom_range(0, 3));
                step();
            end
            cfg_en      = 1'b0;
            spike_valid = 1'b0;
        end

`ifdef SYNAPSE_ROW_MC_SPIKE_CNT_EN
        // counter wrap: 65537 accepted spikes leave a count of 1
        do_reset();
        spike_valid = 1'b1;
        spike_addr  = AW'(15);
        repeat (65537) step();
        spike_valid = 1'b0;
        chk("count_wrap", {16'd0, cnt0}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
